// File: rtl/vram_arbiter.sv
// Arbitrates one single-port synchronous VRAM between VGA scanout reads and CPU accesses.
// Scanout has absolute priority. The CPU fills free slots, and writes are optionally deferred to vblank.
module vram_arbiter #(
    parameter int ADDR_W              = 17,
    parameter int DATA_W              = 8,
    parameter int CPU_WAIT_MAX        = 64,
    parameter int WRITE_IN_BLANK_ONLY = 0
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              vblank,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_starve,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                WAIT_W   = $clog2(CPU_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(CPU_WAIT_MAX);

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_WR_ACK,
        CPU_RD_WAIT,
        CPU_RD_ACK
    } cpu_state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VID,
        TAG_CPU
    } read_tag_t;

    cpu_state_t        cpu_state;
    read_tag_t         tag_issue;
    read_tag_t         tag_return;
    logic [WAIT_W-1:0] wait_cnt;
    logic              cpu_allowed;
    logic              cpu_eligible;
    logic              cpu_grant;

    // The request is ignored while cpu_ack is high, because the master is still updating it.
    always_comb begin
        cpu_allowed  = !cpu_we || (WRITE_IN_BLANK_ONLY == 0) || vblank;
        cpu_eligible = cpu_req && (cpu_state == CPU_IDLE) && !cpu_ack;
        cpu_grant    = !vid_req && cpu_eligible && cpu_allowed;
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            tag_issue <= TAG_NONE;
        end else begin
            mem_we    <= 1'b0;
            tag_issue <= TAG_NONE;
            if (vid_req) begin
                mem_addr  <= vid_addr;
                tag_issue <= TAG_VID;
            end else if (cpu_grant) begin
                mem_addr  <= cpu_addr;
                mem_we    <= cpu_we;
                mem_wdata <= cpu_wdata;
                tag_issue <= cpu_we ? TAG_NONE : TAG_CPU;
            end
        end
    end

    // The RAM samples the address one edge after the grant, and its data is captured on the edge after that.
    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            tag_return <= TAG_NONE;
            vid_valid  <= 1'b0;
            vid_rdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            tag_return <= tag_issue;
            vid_valid  <= (tag_return == TAG_VID);
            if (tag_return == TAG_VID) begin
                vid_rdata <= mem_rdata;
            end
            if (tag_return == TAG_CPU) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            cpu_state <= CPU_IDLE;
            cpu_ack   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (cpu_state)
                CPU_IDLE: begin
                    if (cpu_grant) begin
                        cpu_state <= cpu_we ? CPU_WR_ACK : CPU_RD_WAIT;
                    end
                end
                CPU_WR_ACK: begin
                    cpu_ack   <= 1'b1;
                    cpu_state <= CPU_IDLE;
                end
                CPU_RD_WAIT: begin
                    cpu_state <= CPU_RD_ACK;
                end
                CPU_RD_ACK: begin
                    cpu_ack   <= 1'b1;
                    cpu_state <= CPU_IDLE;
                end
                default: begin
                    cpu_state <= CPU_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= '0;
            cpu_starve <= 1'b0;
        end else if (cpu_grant) begin
            wait_cnt <= '0;
        end else if (cpu_eligible && (wait_cnt != WAIT_SAT)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_SAT - 1'b1) begin
                cpu_starve <= 1'b1;
            end
        end
    end

endmodule
